ysyx_22050550_wb_arbiter: RTL and testbench

Writeback arbiter for the NPC pipeline. It accepts completed results from the EXU (ALU/CSR/MUL) and the LSU (loads) over valid/ready channels and grants at most one per cycle with round-robin fairness. It drives the single register-file write port and, in the same cycle, the scoreboard release port (`WBU_waddr`/`WBU_wen`) that clears the busy bit IDU set at issue. It also counts retired instructions for difftest and perf.

---
 rtl/ysyx_22050550_wb_arbiter_if.sv | 46 ++++
 rtl/ysyx_22050550_wb_arbiter.sv | 93 +++++++++
 tb/tb_ysyx_22050550_wb_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050550_wb_arbiter_if.sv
// Writeback arbiter bus bundle.
// Groups the two result channels (EXU, LSU), the register-file write port,
// the scoreboard release port and the commit/retire outputs.
//   slave  : arbiter view (takes results, drives ready/RF/SB/commit)
//   master : environment view (pipeline stages, RF, scoreboard, perf)
interface ysyx_22050550_wb_arbiter_if #(
    parameter int XLEN = 64
);
    logic            io_EXU_valid;
    logic            io_EXU_ready;
    logic [4:0]      io_EXU_waddr;
    logic            io_EXU_wen;
    logic [XLEN-1:0] io_EXU_wdata;

    logic            io_LSU_valid;
    logic            io_LSU_ready;
    logic [4:0]      io_LSU_waddr;
    logic            io_LSU_wen;
    logic [XLEN-1:0] io_LSU_wdata;

    logic            io_RF_wen;
    logic [4:0]      io_RF_waddr;
    logic [XLEN-1:0] io_RF_wdata;
    logic            io_SB_wen;
    logic [4:0]      io_SB_waddr;
    logic            io_commit;
    logic [XLEN-1:0] io_retire_cnt;

    modport slave (
        input  io_EXU_valid, io_EXU_waddr, io_EXU_wen, io_EXU_wdata,
        input  io_LSU_valid, io_LSU_waddr, io_LSU_wen, io_LSU_wdata,
        output io_EXU_ready, io_LSU_ready,
        output io_RF_wen, io_RF_waddr, io_RF_wdata,
        output io_SB_wen, io_SB_waddr,
        output io_commit, io_retire_cnt
    );

    modport master (
        output io_EXU_valid, io_EXU_waddr, io_EXU_wen, io_EXU_wdata,
        output io_LSU_valid, io_LSU_waddr, io_LSU_wen, io_LSU_wdata,
        input  io_EXU_ready, io_LSU_ready,
        input  io_RF_wen, io_RF_waddr, io_RF_wdata,
        input  io_SB_wen, io_SB_waddr,
        input  io_commit, io_retire_cnt
    );
endinterface

// File: rtl/ysyx_22050550_wb_arbiter.sv
// Writeback arbiter: round-robin select between the EXU and LSU result
// channels, one grant per cycle, registered RF write / scoreboard release,
// commit pulse and retire counter.
// Ports:
//   clock  - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - ysyx_22050550_wb_arbiter_if.slave (channels, RF/SB ports,
//            io_commit, io_retire_cnt); its XLEN must match this XLEN.
module ysyx_22050550_wb_arbiter #(
    parameter int XLEN = 64
) (
    input  logic                            clock,
    input  logic                            reset,
    ysyx_22050550_wb_arbiter_if.slave       bus
);
    typedef enum logic {
        GRANT_EXU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

    grant_e          last_grant;
    logic            grant_exu;
    logic            grant_lsu;
    logic [4:0]      sel_waddr;
    logic            sel_wen;
    logic [XLEN-1:0] sel_wdata;

    logic            wen_q;
    logic [4:0]      waddr_q;
    logic [XLEN-1:0] wdata_q;
    logic            commit_q;
    logic [XLEN-1:0] retire_cnt_q;

    // Ready doubles as the grant; forced low during reset so nothing is
    // accepted in a reset cycle.
    always_comb begin
        grant_exu = 1'b0;
        grant_lsu = 1'b0;
        if (!reset) begin
            if (bus.io_EXU_valid && bus.io_LSU_valid) begin
                // Tie: the channel that did not win last time goes now.
                if (last_grant == GRANT_LSU) begin
                    grant_exu = 1'b1;
                end else begin
                    grant_lsu = 1'b1;
                end
            end else begin
                grant_exu = bus.io_EXU_valid;
                grant_lsu = bus.io_LSU_valid;
            end
        end
        sel_waddr = grant_lsu ? bus.io_LSU_waddr : bus.io_EXU_waddr;
        sel_wen   = grant_lsu ? bus.io_LSU_wen   : bus.io_EXU_wen;
        sel_wdata = grant_lsu ? bus.io_LSU_wdata : bus.io_EXU_wdata;
    end

    assign bus.io_EXU_ready = grant_exu;
    assign bus.io_LSU_ready = grant_lsu;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant   <= GRANT_EXU;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            commit_q     <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            if (grant_exu || grant_lsu) begin
                // Writes to x0 still retire but never touch RF or scoreboard.
                wen_q      <= sel_wen && (sel_waddr != 5'd0);
                waddr_q    <= sel_waddr;
                wdata_q    <= sel_wdata;
                commit_q   <= 1'b1;
                last_grant <= grant_lsu ? GRANT_LSU : GRANT_EXU;
            end else begin
                wen_q    <= 1'b0;
                commit_q <= 1'b0;
            end
            if (commit_q) begin
                retire_cnt_q <= retire_cnt_q + XLEN'(1);
            end
        end
    end

    assign bus.io_RF_wen     = wen_q;
    assign bus.io_RF_waddr   = waddr_q;
    assign bus.io_RF_wdata   = wdata_q;
    assign bus.io_SB_wen     = wen_q;
    assign bus.io_SB_waddr   = waddr_q;
    assign bus.io_commit     = commit_q;
    assign bus.io_retire_cnt = retire_cnt_q;
endmodule

// File: tb/tb_ysyx_22050550_wb_arbiter.sv
// Bench for the writeback arbiter: transaction-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_ysyx_22050550_wb_arbiter;
    localparam int XLEN = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;

    ysyx_22050550_wb_arbiter_if #(.XLEN(XLEN)) bus ();

    ysyx_22050550_wb_arbiter #(.XLEN(XLEN)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int          m_last = 0;     // channel that won the most recent transfer: 0 EXU, 1 LSU
    bit          m_wen = 0;
    bit          m_commit = 0;
    logic [4:0]  m_waddr = '0;
    logic [63:0] m_wdata = '0;
    logic [63:0] m_cnt = '0;

    // Who must be served this cycle: -1 nobody, 0 EXU, 1 LSU.
    function automatic int winner();
        if (reset) return -1;
        if (bus.io_EXU_valid && bus.io_LSU_valid) return 1 - m_last;
        if (bus.io_EXU_valid) return 0;
        if (bus.io_LSU_valid) return 1;
        return -1;
    endfunction

    always @(posedge clock) begin
        int w;
        w = winner();
        if (reset) begin
            m_last = 0; m_wen = 0; m_commit = 0;
            m_waddr = '0; m_wdata = '0; m_cnt = '0;
        end else begin
            if (m_commit) m_cnt = m_cnt + 64'd1;
            if (w == 0) begin
                m_wen = bus.io_EXU_wen && (bus.io_EXU_waddr != 0);
                m_waddr = bus.io_EXU_waddr; m_wdata = bus.io_EXU_wdata;
                m_commit = 1; m_last = 0;
            end else if (w == 1) begin
                m_wen = bus.io_LSU_wen && (bus.io_LSU_waddr != 0);
                m_waddr = bus.io_LSU_waddr; m_wdata = bus.io_LSU_wdata;
                m_commit = 1; m_last = 1;
            end else begin
                m_wen = 0; m_commit = 0;
            end
        end
    end

    always @(negedge clock) begin
        int w;
        w = winner();
        check("EXU_ready",  bus.io_EXU_ready,  64'(w == 0));
        check("LSU_ready",  bus.io_LSU_ready,  64'(w == 1));
        check("RF_wen",     bus.io_RF_wen,     64'(m_wen));
        check("SB_wen",     bus.io_SB_wen,     64'(m_wen));
        check("commit",     bus.io_commit,     64'(m_commit));
        check("RF_waddr",   bus.io_RF_waddr,   64'(m_waddr));
        check("SB_waddr",   bus.io_SB_waddr,   64'(m_waddr));
        check("RF_wdata",   bus.io_RF_wdata,   m_wdata);
        check("retire_cnt", bus.io_retire_cnt, m_cnt);
    end

    // ---------------- stimulus ----------------
    task automatic drive_exu(input bit v, input logic [4:0] a, input bit we, input logic [63:0] d);
        bus.io_EXU_valid = v; bus.io_EXU_waddr = a; bus.io_EXU_wen = we; bus.io_EXU_wdata = d;
    endtask

    task automatic drive_lsu(input bit v, input logic [4:0] a, input bit we, input logic [63:0] d);
        bus.io_LSU_valid = v; bus.io_LSU_waddr = a; bus.io_LSU_wen = we; bus.io_LSU_wdata = d;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        drive_exu(1, 5'd11, 1, 64'hAA);
        drive_lsu(1, 5'd10, 1, 64'hBB);

        // Reset held for three edges with both channels valid.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_EXU_ready", bus.io_EXU_ready, 64'd0);
            check("rst_LSU_ready", bus.io_LSU_ready, 64'd0);
        end
        check("rst_RF_wen", bus.io_RF_wen, 64'd0);
        check("rst_SB_wen", bus.io_SB_wen, 64'd0);
        check("rst_commit", bus.io_commit, 64'd0);
        check("rst_cnt",    bus.io_retire_cnt, 64'd0);
        reset = 0;

        // Single EXU write.
        drive_exu(1, 5'd5, 1, 64'h1234);
        drive_lsu(0, 5'd0, 0, 64'h0);
        #1;
        check("single_EXU_ready", bus.io_EXU_ready, 64'd1);
        tick();
        drive_exu(0, 5'd5, 1, 64'h1234);
        check("single_RF_wen",   bus.io_RF_wen,   64'd1);
        check("single_RF_waddr", bus.io_RF_waddr, 64'd5);
        check("single_RF_wdata", bus.io_RF_wdata, 64'h1234);
        check("single_SB_wen",   bus.io_SB_wen,   64'd1);
        check("single_SB_waddr", bus.io_SB_waddr, 64'd5);
        check("single_commit",   bus.io_commit,   64'd1);
        tick();
        check("single_cnt", bus.io_retire_cnt, 64'd1);

        // Fresh reset so the tie starts from last_grant = EXU.
        reset = 1;
        tick();
        reset = 0;

        // Tie and alternation: LSU, EXU, LSU, EXU.
        drive_lsu(1, 5'd10, 1, 64'h100);
        drive_exu(1, 5'd11, 1, 64'h200);
        for (int k = 0; k < 5; k++) begin
            #1;
            if (k < 4) begin
                check("tie_LSU_ready", bus.io_LSU_ready, 64'(k % 2 == 0));
                check("tie_EXU_ready", bus.io_EXU_ready, 64'(k % 2 == 1));
            end
            if (k > 0) begin
                check("tie_RF_waddr", bus.io_RF_waddr, (k % 2 == 1) ? 64'd10 : 64'd11);
                check("tie_RF_wdata", bus.io_RF_wdata,
                      (k % 2 == 1) ? 64'h100 + 64'((k - 1) / 2) : 64'h200 + 64'((k - 2) / 2));
            end
            tick();
            if (k < 4) begin
                if (k % 2 == 0) bus.io_LSU_wdata = bus.io_LSU_wdata + 64'd1;
                else            bus.io_EXU_wdata = bus.io_EXU_wdata + 64'd1;
            end
            if (k == 3) begin
                bus.io_LSU_valid = 0;
                bus.io_EXU_valid = 0;
            end
        end

        // x0 write then a no-write instruction.
        drive_exu(1, 5'd0, 1, 64'hDEAD);
        tick();
        drive_exu(0, 5'd0, 1, 64'hDEAD);
        drive_lsu(1, 5'd7, 0, 64'hBEEF);
        check("x0_RF_wen",  bus.io_RF_wen, 64'd0);
        check("x0_SB_wen",  bus.io_SB_wen, 64'd0);
        check("x0_commit",  bus.io_commit, 64'd1);
        tick();
        drive_lsu(0, 5'd7, 0, 64'hBEEF);
        check("nowr_RF_wen",   bus.io_RF_wen,   64'd0);
        check("nowr_SB_wen",   bus.io_SB_wen,   64'd0);
        check("nowr_commit",   bus.io_commit,   64'd1);
        check("nowr_RF_waddr", bus.io_RF_waddr, 64'd7);
        tick();
        check("x0_cnt", bus.io_retire_cnt, 64'd6);

        // Back-pressure: LSU won last, so EXU goes first; LSU holds its data.
        drive_exu(1, 5'd12, 1, 64'hE1);
        drive_lsu(1, 5'd20, 1, 64'hF1);
        #1;
        check("bp_EXU_ready", bus.io_EXU_ready, 64'd1);
        check("bp_LSU_ready", bus.io_LSU_ready, 64'd0);
        tick();
        drive_exu(0, 5'd12, 1, 64'hE1);
        check("bp_LSU_ready2", bus.io_LSU_ready, 64'd1);
        check("bp_RF_waddr1",  bus.io_RF_waddr,  64'd12);
        check("bp_RF_wdata1",  bus.io_RF_wdata,  64'hE1);
        tick();
        drive_lsu(0, 5'd20, 1, 64'hF1);
        check("bp_RF_waddr2", bus.io_RF_waddr, 64'd20);
        check("bp_RF_wdata2", bus.io_RF_wdata, 64'hF1);
        check("bp_commit2",   bus.io_commit,   64'd1);
        tick();
        check("bp_no_dup", bus.io_commit,      64'd0);
        check("bp_cnt",    bus.io_retire_cnt,  64'd8);

        // Reset mid-flight: accepted result is dropped.
        drive_exu(1, 5'd3, 1, 64'h33);
        #1;
        check("mid_EXU_ready", bus.io_EXU_ready, 64'd1);
        tick();
        drive_exu(0, 5'd3, 1, 64'h33);
        reset = 1;
        tick();
        reset = 0;
        check("mid_RF_wen", bus.io_RF_wen,       64'd0);
        check("mid_commit", bus.io_commit,       64'd0);
        check("mid_cnt",    bus.io_retire_cnt,   64'd0);

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
